// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative MULT/MULTU/DIV/DIVU unit for the EXE stage
// Holds busy while computing and keeps HI/LO valid until the instruction leaves EXE.
module mdu_iterative #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic        flush_i,
   input  logic        advance_i,
   output logic        busy_o,
   output logic        result_valid_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [4:0] LP_MUL_LAST = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] LP_DIV_LAST = 5'd31;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_rem;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_sa;
   logic        r_sb;
   logic        r_divz;

   logic        w_start;
   logic        w_signed;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_prod;
   logic [32:0] w_trial;
   logic        w_ge;
   logic [31:0] w_rem_nx;
   logic [31:0] w_q_nx;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;

   assign w_start  = (r_state == S_IDLE) && start_i && !flush_i;
   assign w_signed = ~op_i[0];
   assign w_neg_a  = w_signed & src_a_i[31];
   assign w_neg_b  = w_signed & src_b_i[31];
   assign w_a_mag  = w_neg_a ? (32'd0 - src_a_i) : src_a_i;
   assign w_b_mag  = w_neg_b ? (32'd0 - src_b_i) : src_b_i;

   // Sign-extending both operands to 64 bits gives the same low 64 bits as a 33x33 signed product.
   assign w_mul_a = {{32{r_sa}}, r_a};
   assign w_mul_b = {{32{r_sb}}, r_b};
   assign w_prod  = w_mul_a * w_mul_b;

   // Restoring step: r_a shifts dividend bits out the top and quotient bits in at the bottom.
   assign w_trial  = {r_rem, r_a[31]};
   assign w_ge     = (w_trial >= {1'b0, r_b});
   assign w_rem_nx = w_ge ? (w_trial[31:0] - r_b) : w_trial[31:0];
   assign w_q_nx   = {r_a[30:0], w_ge};
   assign w_q_fix  = (r_sa ^ r_sb) ? (32'd0 - w_q_nx) : w_q_nx;
   assign w_r_fix  = r_sa ? (32'd0 - w_rem_nx) : w_rem_nx;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start_i) w_next = op_i[1] ? S_DIV : S_MUL;
         S_MUL:  if (r_cnt == LP_MUL_LAST) w_next = S_DONE;
         S_DIV:  if (r_cnt == LP_DIV_LAST) w_next = S_DONE;
         S_DONE: if (advance_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush_i) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_rem   <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_divz  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               r_cnt <= 5'd0;
               if (w_start) begin
                  r_sa   <= w_neg_a;
                  r_sb   <= w_neg_b;
                  r_divz <= (src_b_i == 32'd0);
                  r_rem  <= 32'd0;
                  r_a    <= op_i[1] ? w_a_mag : src_a_i;
                  r_b    <= op_i[1] ? w_b_mag : src_b_i;
               end
            end
            S_MUL: begin
               r_cnt <= r_cnt + 5'd1;
               if (!flush_i && r_cnt == LP_MUL_LAST) begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
            end
            S_DIV: begin
               r_cnt <= r_cnt + 5'd1;
               r_a   <= w_q_nx;
               r_rem <= w_rem_nx;
               // Divide by zero: the remainder already equals the dividend, only LO needs forcing.
               if (!flush_i && r_cnt == LP_DIV_LAST) begin
                  r_hi <= w_r_fix;
                  r_lo <= r_divz ? 32'hFFFF_FFFF : w_q_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o = !flush_i && (((r_state == S_IDLE) && start_i) ||
                                (r_state == S_MUL) || (r_state == S_DIV));
   assign result_valid_o = (r_state == S_DONE);
   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;

   localparam int MC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] src_a_i;
   logic [31:0] src_b_i;
   logic        flush_i;
   logic        advance_i;
   logic        busy_o;
   logic        result_valid_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks = 0;
   int errors = 0;

   mdu_iterative #(.MUL_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
      .advance_i(advance_i), .busy_o(busy_o), .result_valid_o(result_valid_o),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
      start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
      #1;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL %s busy_at_start got %0b exp 1", nm, busy_o);
      end
   endtask

   task automatic wait_done(input int lat, input string nm);
      int n = 0;
      bit busy_ok = 1'b1;
      while (result_valid_o !== 1'b1 && n < 200) begin
         step();
         n++;
         if (result_valid_o !== 1'b1 && busy_o !== 1'b1) busy_ok = 1'b0;
      end
      checks++;
      if (n != lat) begin
         errors++; $display("FAIL %s latency got %0d exp %0d", nm, n, lat);
      end
      checks++;
      if (!busy_ok) begin
         errors++; $display("FAIL %s busy_while_running got 0 exp 1", nm);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL %s busy_in_done got %0b exp 0", nm, busy_o);
      end
   endtask

   task automatic check_result(input logic [31:0] eh, input logic [31:0] el, input string nm);
      checks++;
      if (hi_o !== eh) begin
         errors++; $display("FAIL %s hi got %08h exp %08h", nm, hi_o, eh);
      end
      checks++;
      if (lo_o !== el) begin
         errors++; $display("FAIL %s lo got %08h exp %08h", nm, lo_o, el);
      end
   endtask

   task automatic retire(input string nm);
      advance_i = 1'b1;
      step();
      advance_i = 1'b0; start_i = 1'b0;
      #1;
      checks++;
      if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s retire valid/busy got %0b/%0b exp 0/0", nm, result_valid_o, busy_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; op_i = 2'b00; src_a_i = 32'd0; src_b_i = 32'd0;
      flush_i = 1'b0; advance_i = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
         errors++;
         $display("FAIL reset busy/valid/hi/lo got %0b/%0b/%08h/%08h exp 0/0/0/0",
                  busy_o, result_valid_o, hi_o, lo_o);
      end
      step();
   endtask

   task automatic test_mul();
      issue(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      wait_done(MC + 1, "mult_neg");
      check_result(32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
      retire("mult_neg");
      issue(2'b01, 32'hFFFF_FFFD, 32'd7, "multu");
      wait_done(MC + 1, "multu");
      check_result(32'h0000_0006, 32'hFFFF_FFEB, "multu");
      retire("multu");
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min");
      wait_done(MC + 1, "mult_min");
      check_result(32'h4000_0000, 32'h0000_0000, "mult_min");
      retire("mult_min");
   endtask

   task automatic test_div();
      issue(2'b11, 32'd100, 32'd7, "divu");
      wait_done(33, "divu");
      check_result(32'd2, 32'd14, "divu");
      retire("divu");
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg_dividend");
      wait_done(33, "div_neg_dividend");
      check_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_dividend");
      retire("div_neg_dividend");
      issue(2'b10, 32'd7, 32'hFFFF_FFFE, "div_neg_divisor");
      wait_done(33, "div_neg_divisor");
      check_result(32'h0000_0001, 32'hFFFF_FFFD, "div_neg_divisor");
      retire("div_neg_divisor");
   endtask

   task automatic test_div_special();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      wait_done(33, "div_overflow");
      check_result(32'h0000_0000, 32'h8000_0000, "div_overflow");
      retire("div_overflow");
      issue(2'b11, 32'd5, 32'd0, "divu_by_zero");
      wait_done(33, "divu_by_zero");
      check_result(32'd5, 32'hFFFF_FFFF, "divu_by_zero");
      retire("divu_by_zero");
      issue(2'b10, 32'hFFFF_FFF9, 32'd0, "div_by_zero");
      wait_done(33, "div_by_zero");
      check_result(32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by_zero");
      retire("div_by_zero");
   endtask

   task automatic test_flush();
      bit seen_valid = 1'b0;
      issue(2'b10, 32'd100, 32'd7, "flush_div");
      repeat (10) begin
         step();
         if (result_valid_o !== 1'b0) seen_valid = 1'b1;
      end
      flush_i = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL flush_busy got %0b exp 0", busy_o);
      end
      step();
      flush_i = 1'b0;
      if (result_valid_o !== 1'b0) seen_valid = 1'b1;
      checks++;
      if (seen_valid) begin
         errors++; $display("FAIL flush_no_result got valid=1 exp never");
      end
      issue(2'b01, 32'hFFFF_FFFD, 32'd7, "after_flush");
      wait_done(MC + 1, "after_flush");
      check_result(32'h0000_0006, 32'hFFFF_FFEB, "after_flush");
      retire("after_flush");
   endtask

   task automatic test_back_to_back();
      issue(2'b00, 32'd3, 32'd5, "stall_mult");
      wait_done(MC + 1, "stall_mult");
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (result_valid_o !== 1'b1 || hi_o !== 32'd0 || lo_o !== 32'd15 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d valid/hi/lo/busy got %0b/%08h/%08h/%0b exp 1/0/f/0",
                     i, result_valid_o, hi_o, lo_o, busy_o);
         end
      end
      advance_i = 1'b1;
      step();
      advance_i = 1'b0;
      checks++;
      if (result_valid_o !== 1'b0) begin
         errors++; $display("FAIL b2b_idle valid got %0b exp 0", result_valid_o);
      end
      issue(2'b11, 32'd100, 32'd7, "b2b_divu");
      wait_done(33, "b2b_divu");
      check_result(32'd2, 32'd14, "b2b_divu");
      retire("b2b_divu");
   endtask

   task automatic test_reset_mid_div();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rst_div");
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0; start_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid busy/valid/hi/lo got %0b/%0b/%08h/%08h exp 0/0/0/0",
                  busy_o, result_valid_o, hi_o, lo_o);
      end
      issue(2'b11, 32'd100, 32'd7, "after_rst");
      wait_done(33, "after_rst");
      check_result(32'd2, 32'd14, "after_rst");
      retire("after_rst");
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_special();
      test_flush();
      test_back_to_back();
      test_reset_mid_div();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
